// File: rtl/dsp_pkg.sv
// Shared DSP definitions: FIR sequencing states, accumulator sizing and
// the round/saturate step used when narrowing accumulators to sample width.
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  // Working width of round_sat; callers sign-extend their accumulator to it.
  localparam int RS_WIDTH = 64;

  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

  // Round half up by 2^frac, then clamp to a signed dw-bit range (frac >= 1).
  function automatic logic signed [RS_WIDTH-1:0] round_sat(
    input logic signed [RS_WIDTH-1:0] acc,
    input int                         frac,
    input int                         dw
  );
    logic signed [RS_WIDTH-1:0] r;
    logic signed [RS_WIDTH-1:0] hi;
    logic signed [RS_WIDTH-1:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// Single signed multiply-accumulate stage shared across all FIR taps.
// clr has priority over en so a new sample always starts from zero.
module fir_tap_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 37
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] coeff,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] product;

  assign product = coeff * sample;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // updates from values sampled before the edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_WIDTH - 2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed direct-form FIR: one MAC iterated over all taps per sample,
// with valid/ready handshakes on both the sample input and the result output.
module fir_mac_engine
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 30,
  parameter int FRAC_BITS  = 15
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           en,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] coeffs,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_sample,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_sample,
  output logic                           busy
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, NUM_TAPS);
  localparam int TAP_W     = $clog2(NUM_TAPS + 1);
  // tap == DRAIN is the extra MAC cycle in which the final sum is registered.
  localparam logic [TAP_W-1:0] DRAIN = TAP_W'(NUM_TAPS);

  fir_state_t                    state;
  logic [TAP_W-1:0]              tap;
  logic signed [DATA_WIDTH-1:0]  x [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  h_sel;
  logic signed [DATA_WIDTH-1:0]  x_sel;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [RS_WIDTH-1:0]    acc_ext;
  logic signed [RS_WIDTH-1:0]    rounded;
  logic                          accept;
  logic                          mac_en;

  assign in_ready = (state == IDLE) && en;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign mac_en   = (state == MAC) && (tap != DRAIN);

  // NOTE: every output of this block gets a default first, so the tap
  // mux cannot infer a latch for unmatched tap values.
  always_comb begin
    h_sel = '0;
    x_sel = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (tap == TAP_W'(i)) begin
        h_sel = coeffs[i*DATA_WIDTH +: DATA_WIDTH];
        x_sel = x[i];
      end
    end
  end

  fir_tap_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (accept),
    .en     (mac_en),
    .coeff  (h_sel),
    .sample (x_sel),
    .acc    (acc)
  );

  assign acc_ext = {{(RS_WIDTH - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
  assign rounded = round_sat(acc_ext, FRAC_BITS, DATA_WIDTH);

  // NOTE: the delay line is a small bank of flops, not a RAM, so it can
  // take the asynchronous reset like any other register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
    end else if (state == IDLE) begin
      if (!en) begin
        for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
      end else if (accept) begin
        x[0] <= in_sample;
        for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      tap        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (tap == DRAIN) begin
            out_sample <= rounded[DATA_WIDTH-1:0];
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            tap <= tap + TAP_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: impulse, rounding, saturation,
// backpressure, enable handling and reset during MAC.
module tb_fir_mac_engine;

  localparam int DW = 16;
  localparam int NT = 30;
  localparam int FB = 15;

  logic                  clk;
  logic                  arst_n;
  logic                  en;
  logic [NT*DW-1:0]      coeffs;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_sample;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  out_sample;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;

  fir_mac_engine #(
    .DATA_WIDTH (DW),
    .NUM_TAPS   (NT),
    .FRAC_BITS  (FB)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .en         (en),
    .coeffs     (coeffs),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coeff(input int idx, input int val);
    coeffs[idx*DW +: DW] = 16'(val);
  endtask

  // Send one sample with out_ready high; returns result and accept-to-valid cycles.
  task automatic run_sample(input int s, output int y, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    in_valid  = 1'b1;
    in_sample = 16'(s);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    y = int'(out_sample);
    step();
  endtask

  task automatic clear_line();
    en = 1'b0;
    step();
    step();
    en = 1'b1;
  endtask

  int y;
  int lat;
  int cnt;
  int seen;
  int gain_in  [4] = '{1000, 1, -1, -3};
  int gain_exp [4] = '{500, 1, 0, -1};

  initial begin
    arst_n    = 1'b0;
    en        = 1'b0;
    coeffs    = '0;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_in_ready_en0", in_ready, 0);
    arst_n = 1'b1;
    en     = 1'b1;
    #1;
    check("rst_in_ready_en1", in_ready, 1);
    step();

    // Impulse response: h[i] = 100*(i+1), input 16384 then zeros.
    for (int i = 0; i < NT; i++) set_coeff(i, 100 * (i + 1));
    for (int n = 0; n <= NT; n++) begin
      run_sample((n == 0) ? 16384 : 0, y, lat);
      check($sformatf("impulse_%0d", n), y, (n < NT) ? 50 * (n + 1) : 0);
      if (n == 0) check("impulse_latency", lat, 31);
    end

    // Gain 0.5 on h[0]: exercises round half up on negative values.
    coeffs = '0;
    set_coeff(0, 16384);
    for (int i = 0; i < 4; i++) begin
      run_sample(gain_in[i], y, lat);
      check($sformatf("gain_%0d", i), y, gain_exp[i]);
    end

    // Backpressure: hold out_ready low 5 cycles with next input already waiting.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'sd1000;
    step();
    in_sample = 16'sd200;
    check("bp_busy_mac", busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      step();
      cnt++;
    end
    check("bp_latency", cnt, 31);
    check("bp_first_value", out_sample, 500);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_hold_sample_%0d", i), out_sample, 500);
      check($sformatf("bp_hold_in_ready_%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_no_duplicate", out_valid, 0);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      step();
      cnt++;
      in_valid = 1'b0;
    end
    check("bp_release_to_next", cnt, 32);
    check("bp_second_value", out_sample, 100);
    step();
    check("bp_second_consumed", out_valid, 0);

    // Saturation at both rails with all taps at full scale.
    for (int i = 0; i < NT; i++) set_coeff(i, 32767);
    clear_line();
    run_sample(32767, y, lat);
    check("sat_pos_0", y, 32766);
    for (int i = 1; i < 4; i++) begin
      run_sample(32767, y, lat);
      check($sformatf("sat_pos_%0d", i), y, 32767);
    end
    clear_line();
    run_sample(-32768, y, lat);
    check("sat_neg_0", y, -32767);
    for (int i = 1; i < 3; i++) begin
      run_sample(-32768, y, lat);
      check($sformatf("sat_neg_%0d", i), y, -32768);
    end

    // Enable dropped mid-MAC: result still delivered, then history cleared.
    coeffs = '0;
    set_coeff(0, 16384);
    run_sample(1000, y, lat);
    check("en_prime", y, 500);
    in_valid  = 1'b1;
    in_sample = 16'sd2000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b0;
    #1;
    check("en_off_busy", busy, 1);
    check("en_off_in_ready", in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      step();
      cnt++;
    end
    check("en_off_result", out_sample, 1000);
    step();
    check("en_off_consumed", out_valid, 0);
    check("en_off_idle_in_ready", in_ready, 0);
    step();
    step();
    coeffs = '0;
    set_coeff(1, 32767);
    en = 1'b1;
    run_sample(5, y, lat);
    check("en_restart_cleared", y, 0);
    run_sample(7, y, lat);
    check("en_restart_h1", y, 5);

    // Reset at tap 10: no output for that sample, then a clean restart.
    in_valid  = 1'b1;
    in_sample = 16'sd9;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("rmid_busy_before", busy, 1);
    arst_n = 1'b0;
    #1;
    check("rmid_out_valid", out_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_out_sample", out_sample, 0);
    check("rmid_in_ready", in_ready, 1);
    #2;
    arst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("rmid_no_output", seen, 0);
    run_sample(3, y, lat);
    check("rmid_zero_history", y, 0);
    run_sample(4, y, lat);
    check("rmid_next_correct", y, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
